// File: rtl/cube_pkg.sv
// cube_pkg: pixel-point type, frame constants and packing helper shared by the projector and the overlay stage.
package cube_pkg;

  localparam int CORD_SIZE = 11;
  localparam int MAX_X     = 1226;
  localparam int MAX_Y     = 370;
  localparam int PAD_W     = 16 - CORD_SIZE;

  typedef struct packed {
    logic [PAD_W-1:0]     pad_y;
    logic [CORD_SIZE-1:0] y;
    logic [PAD_W-1:0]     pad_x;
    logic [CORD_SIZE-1:0] x;
  } cube_pt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE
  } proj_state_t;

  function automatic cube_pt_t pack_pt(input logic [CORD_SIZE-1:0] u,
                                       input logic [CORD_SIZE-1:0] v);
    cube_pt_t p;
    p.pad_y = '0;
    p.y     = v;
    p.pad_x = '0;
    p.x     = u;
    return p;
  endfunction

endpackage

// File: rtl/cube_projector_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, DIV_W cycles from start to done.
// A zero divisor yields an all-ones quotient.
module seq_divider #(
  parameter int DIV_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [DIV_W-1:0] srcRem, srcQuo, srcDvs;
  logic [DIV_W:0]   shifted;
  logic             fits;

  // The first bit is resolved on the start edge itself, so done rises exactly DIV_W cycles later.
  always_comb begin
    srcRem  = start ? '0 : rem_q;
    srcQuo  = start ? dividend : quo_q;
    srcDvs  = start ? divisor : dvs_q;
    shifted = {srcRem, srcQuo[DIV_W-1]};
    fits    = (shifted >= {1'b0, srcDvs});
    rem_d   = fits ? (shifted[DIV_W-1:0] - srcDvs) : shifted[DIV_W-1:0];
    quo_d   = {srcQuo[DIV_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= divisor;
      cnt_q  <= CNT_W'(DIV_W - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - CNT_W'(1);
      busy_q <= (cnt_q != CNT_W'(1));
      done_q <= (cnt_q == CNT_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/cube_projector.sv
// cube_projector: pinhole projection of 8 cube vertices into double-buffered pixel points, published on vsync.
// Define CUBE_PROJ_CLIP_EN to saturate coordinates to the frame instead of wrapping modulo 2^CORD_SIZE.
module cube_projector
  import cube_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int FOCAL_W = 12,
  parameter int DIV_W   = COORD_W + FOCAL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0][COORD_W-1:0] vtx_x,
  input  logic [7:0][COORD_W-1:0] vtx_y,
  input  logic [7:0][COORD_W-1:0] vtx_z,
  input  logic [FOCAL_W-1:0]      fx,
  input  logic [FOCAL_W-1:0]      fy,
  input  logic [CORD_SIZE-1:0]    cx,
  input  logic [CORD_SIZE-1:0]    cy,
  input  logic                    vsync_in,
  output logic                    busy,
  output logic                    done,
  output logic [7:0][31:0]        cube_pts,
  output logic [7:0]              behind,
  output logic                    pts_valid
);

  localparam int RW = CORD_SIZE + DIV_W + 1;

  proj_state_t                 state_q;
  logic [3:0]                  job_q;
  logic                        sign_q;
  logic [7:0][COORD_W-1:0]     vx_q, vy_q, vz_q;
  logic [FOCAL_W-1:0]          fx_q, fy_q;
  logic [CORD_SIZE-1:0]        cx_q, cy_q;
  cube_pt_t [7:0]              back_q;
  logic [7:0]                  backBehind_q;
  logic [7:0][31:0]            cubePts_q;
  logic [7:0]                  behind_q;
  logic                        ptsValid_q, pending_q, vsync_q, busy_q, done_q;

  logic [2:0]                  vtxIdx;
  logic                        isV, zPos, vsyncEdge;
  logic signed [COORD_W-1:0]   coord, zVal;
  logic [FOCAL_W-1:0]          focal;
  logic [CORD_SIZE-1:0]        centre, coordPost, coordFinal;
  logic signed [DIV_W-1:0]     num;
  logic [DIV_W-1:0]            numMag, zMag, divQuot;
  logic signed [RW-1:0]        qExt, cExt, r;
  logic                        divStart, divBusy, divDone;

  // Job bit 0 selects u/v, bits [3:1] the vertex; the same operands serve LOAD (divider inputs) and STORE.
  always_comb begin
    vtxIdx    = job_q[3:1];
    isV       = job_q[0];
    coord     = isV ? vy_q[vtxIdx] : vx_q[vtxIdx];
    zVal      = vz_q[vtxIdx];
    focal     = isV ? fy_q : fx_q;
    centre    = isV ? cy_q : cx_q;
    num       = DIV_W'(signed'({1'b0, focal})) * DIV_W'(coord);
    numMag    = num[DIV_W-1] ? $unsigned(-num) : $unsigned(num);
    zMag      = DIV_W'($unsigned(zVal[COORD_W-1] ? -zVal : zVal));
    zPos      = !zVal[COORD_W-1] && (zVal != '0);
    qExt      = signed'(RW'(divQuot));
    cExt      = signed'(RW'(centre));
    r         = sign_q ? (cExt - qExt) : (cExt + qExt);
    vsyncEdge = vsync_in && !vsync_q;
    divStart  = (state_q == S_LOAD) && !divBusy;
  end

`ifdef CUBE_PROJ_CLIP_EN
  logic signed [RW-1:0] rMax;

  always_comb begin
    rMax = isV ? RW'(MAX_Y - 1) : RW'(MAX_X - 1);
    if (r < 0) begin
      coordPost = '0;
    end else if (r > rMax) begin
      coordPost = rMax[CORD_SIZE-1:0];
    end else begin
      coordPost = r[CORD_SIZE-1:0];
    end
  end
`else
  // Only the low CORD_SIZE bits survive the wrap; the rest of r matters solely to the clipping build.
  logic unusedRHi;

  assign coordPost = r[CORD_SIZE-1:0];
  assign unusedRHi = ^r[RW-1:CORD_SIZE];
`endif

  assign coordFinal = zPos ? coordPost : '0;

  seq_divider #(
    .DIV_W(DIV_W)
  ) uDiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (divStart),
    .dividend (numMag),
    .divisor  (zMag),
    .busy     (divBusy),
    .done     (divDone),
    .quotient (divQuot)
  );

  // A swap needs an edge on a cycle where pending was already settled, so a done-coincident edge waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      job_q        <= '0;
      sign_q       <= 1'b0;
      vx_q         <= '0;
      vy_q         <= '0;
      vz_q         <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      back_q       <= '0;
      backBehind_q <= '0;
      cubePts_q    <= '0;
      behind_q     <= '0;
      ptsValid_q   <= 1'b0;
      pending_q    <= 1'b0;
      vsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      done_q  <= 1'b0;
      if (vsyncEdge && pending_q && !done_q) begin
        cubePts_q  <= back_q;
        behind_q   <= backBehind_q;
        ptsValid_q <= 1'b1;
        pending_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vx_q      <= vtx_x;
            vy_q      <= vtx_y;
            vz_q      <= vtx_z;
            fx_q      <= fx;
            fy_q      <= fy;
            cx_q      <= cx;
            cy_q      <= cy;
            job_q     <= '0;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          sign_q  <= num[DIV_W-1];
          state_q <= S_DIV;
        end
        S_DIV: begin
          if (divDone) begin
            state_q <= S_STORE;
          end
        end
        S_STORE: begin
          if (isV) begin
            back_q[vtxIdx] <= pack_pt(back_q[vtxIdx].x, coordFinal);
          end else begin
            back_q[vtxIdx] <= pack_pt(coordFinal, back_q[vtxIdx].y);
          end
          backBehind_q[vtxIdx] <= !zPos;
          if (job_q == 4'd15) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pending_q <= 1'b1;
          end else begin
            job_q   <= job_q + 4'd1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cube_pts  = cubePts_q;
  assign behind    = behind_q;
  assign pts_valid = ptsValid_q;

endmodule

// File: tb/tb_cube_projector.sv
// tb_cube_projector: directed and randomized runs of cube_projector checked against an arithmetic pinhole model.
`timescale 1ns/1ps
module tb_cube_projector;

  localparam int DIV_W   = 28;
  localparam int LATENCY = 16 * (DIV_W + 2) + 1;
  localparam int FRAME_W = 1226;
  localparam int FRAME_H = 370;
`ifdef CUBE_PROJ_CLIP_EN
  localparam int EXP_V1 = 0;
  localparam int EXP_U2 = 1225;
`else
  localparam int EXP_V1 = 1883;
  localparam int EXP_U2 = 69;
`endif

  logic             clk = 1'b0;
  logic             rst_n, start, vsync_in;
  logic [7:0][15:0] vtxX, vtxY, vtxZ;
  logic [11:0]      fx, fy;
  logic [10:0]      cx, cy;
  logic             busy, done, ptsValid;
  logic [7:0][31:0] cubePts;
  logic [7:0]       behind;

  int               checks = 0;
  int               errors = 0;
  int               lastLatency;
  int               doneCount;
  logic [7:0][31:0] expPts, frontPts;
  logic [7:0]       expBehind, frontBehind;

  always #5 clk = ~clk;

  cube_projector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vtx_x     (vtxX),
    .vtx_y     (vtxY),
    .vtx_z     (vtxZ),
    .fx        (fx),
    .fy        (fy),
    .cx        (cx),
    .cy        (cy),
    .vsync_in  (vsync_in),
    .busy      (busy),
    .done      (done),
    .cube_pts  (cubePts),
    .behind    (behind),
    .pts_valid (ptsValid)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pinhole model: c + trunc(f*coord/z), then clip or wrap; vertices at or behind the camera give 0.
  function automatic int projCoord(input int f, input int c, input int crd, input int z, input bit isV);
    longint num, r;
    if (z <= 0) return 0;
    num = longint'(f) * longint'(crd);
    r   = longint'(c) + num / longint'(z);
`ifdef CUBE_PROJ_CLIP_EN
    if (r < 0) return 0;
    if (isV && r > FRAME_H - 1) return FRAME_H - 1;
    if (!isV && r > FRAME_W - 1) return FRAME_W - 1;
    return int'(r);
`else
    if (isV) return int'(r & 64'd2047);
    return int'(r & 64'd2047);
`endif
  endfunction

  task automatic computeExpected();
    int u, v;
    for (int i = 0; i < 8; i++) begin
      u = projCoord(int'(fx), int'(cx), int'($signed(vtxX[i])), int'($signed(vtxZ[i])), 1'b0);
      v = projCoord(int'(fy), int'(cy), int'($signed(vtxY[i])), int'($signed(vtxZ[i])), 1'b1);
      expPts[i]    = {5'b0, 11'(v), 5'b0, 11'(u)};
      expBehind[i] = (int'($signed(vtxZ[i])) <= 0);
    end
  endtask

  task automatic randomVertices();
    for (int i = 0; i < 8; i++) begin
      vtxX[i] = 16'($urandom);
      vtxY[i] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) vtxZ[i] = 16'(-int'($urandom_range(0, 300)));
      else vtxZ[i] = 16'($urandom_range(1, 32767));
    end
    fx = 12'($urandom);
    fy = 12'($urandom);
    cx = 11'($urandom_range(0, FRAME_W - 1));
    cy = 11'($urandom_range(0, FRAME_H - 1));
  endtask

  // Pulses start for one cycle; returns in the first cycle after the accept edge.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseVsync();
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
    tick();
  endtask

  // Watches done for a bounded number of cycles, optionally injecting vsync edges or a second start.
  task automatic runToDone(input int vsyncAt, input int restartAt, input bit vsyncOnDone, input int budget);
    int dropAt;
    dropAt      = -1;
    lastLatency = -1;
    doneCount   = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (done === 1'b1) begin
        doneCount++;
        if (lastLatency < 0) lastLatency = cyc;
        if (vsyncOnDone) begin
          vsync_in = 1'b1;
          dropAt   = cyc + 2;
        end
      end
      if (cyc == vsyncAt) begin
        vsync_in = 1'b1;
        dropAt   = cyc + 2;
      end
      if (cyc == dropAt) vsync_in = 1'b0;
      if (cyc == restartAt) begin
        start = 1'b1;
        randomVertices();
      end
      if (cyc == restartAt + 1) start = 1'b0;
      tick();
    end
    vsync_in = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    vsync_in = 1'b0;
    vtxX     = '0;
    vtxY     = '0;
    vtxZ     = '0;
    fx       = '0;
    fy       = '0;
    cx       = '0;
    cy       = '0;
    repeat (3) tick();

    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_valid", ptsValid, 1'b0);
    checkOutput("reset_behind", behind, 8'h00);
    checkOutput("reset_pts", cubePts, '0);
    rst_n = 1'b1;
    tick();

    $display("[TB] run A: reference vertices plus random fill");
    randomVertices();
    vtxX[0] = 16'd256;
    vtxY[0] = 16'd128;
    vtxZ[0] = 16'd512;
    vtxY[1] = 16'(-256);
    vtxZ[1] = 16'd512;
    vtxX[2] = 16'd2048;
    vtxZ[2] = 16'd256;
    fx = 12'd700;
    fy = 12'd700;
    cx = 11'd613;
    cy = 11'd185;
    computeExpected();
    applyStimulus();
    checkOutput("A_busy_after_accept", busy, 1'b1);
    runToDone(0, 0, 1'b0, 520);
    checkOutput("A_latency", lastLatency, LATENCY);
    checkOutput("A_done_count", doneCount, 1);
    checkOutput("A_busy_idle", busy, 1'b0);
    checkOutput("A_unpublished_valid", ptsValid, 1'b0);
    checkOutput("A_unpublished_pts", cubePts, '0);
    pulseVsync();
    checkOutput("A_pts", cubePts, expPts);
    checkOutput("A_behind", behind, expBehind);
    checkOutput("A_valid", ptsValid, 1'b1);
    checkOutput("A_pt0_const", cubePts[0], 32'h0168_03C3);
    checkOutput("A_v1_const", cubePts[1][26:16], EXP_V1);
    checkOutput("A_u2_const", cubePts[2][10:0], EXP_U2);
    frontPts    = expPts;
    frontBehind = expBehind;

    $display("[TB] run B: vertex 3 on the camera plane, vsync mid-run and coincident with done");
    randomVertices();
    for (int i = 0; i < 8; i++) vtxZ[i] = 16'd512;
    vtxZ[3] = 16'd0;
    computeExpected();
    applyStimulus();
    runToDone(200, 0, 1'b1, 520);
    checkOutput("B_latency", lastLatency, LATENCY);
    checkOutput("B_front_kept", cubePts, frontPts);
    checkOutput("B_front_behind_kept", behind, frontBehind);
    pulseVsync();
    checkOutput("B_pts", cubePts, expPts);
    checkOutput("B_behind", behind, 8'b0000_1000);
    checkOutput("B_pt3_zero", cubePts[3], 32'h0);

    $display("[TB] run C: start re-pulsed while busy");
    randomVertices();
    computeExpected();
    applyStimulus();
    runToDone(0, 10, 1'b0, 1000);
    checkOutput("C_done_count", doneCount, 1);
    checkOutput("C_latency", lastLatency, LATENCY);
    pulseVsync();
    checkOutput("C_pts", cubePts, expPts);
    checkOutput("C_behind", behind, expBehind);

    $display("[TB] run D: reset mid-run");
    randomVertices();
    applyStimulus();
    repeat (99) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("D_busy", busy, 1'b0);
    checkOutput("D_done", done, 1'b0);
    checkOutput("D_valid", ptsValid, 1'b0);
    checkOutput("D_pts", cubePts, '0);
    checkOutput("D_behind", behind, 8'h00);
    rst_n = 1'b1;
    runToDone(0, 0, 1'b0, 600);
    checkOutput("D_no_done", doneCount, 0);
    pulseVsync();
    checkOutput("D_no_swap_valid", ptsValid, 1'b0);
    checkOutput("D_no_swap_pts", cubePts, '0);

    $display("[TB] run E: random runs, first one started right out of reset");
    for (int run = 0; run < 3; run++) begin
      randomVertices();
      computeExpected();
      if (run == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      applyStimulus();
      runToDone(0, 0, 1'b0, 500);
      checkOutput($sformatf("E%0d_latency", run), lastLatency, LATENCY);
      pulseVsync();
      checkOutput($sformatf("E%0d_pts", run), cubePts, expPts);
      checkOutput($sformatf("E%0d_behind", run), behind, expBehind);
      checkOutput($sformatf("E%0d_valid", run), ptsValid, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
